// File: rtl/uart_reg_fabric_if.sv
// Host register bus carried between a bus master and uart_reg_fabric.
interface uart_reg_fabric_if;
  logic        reg_cs;
  logic        reg_wr;
  logic [10:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        reg_err;

  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack, reg_err
  );

  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack, reg_err
  );
endinterface

// File: rtl/uart_reg_fabric.sv
// Host register fabric: routes host accesses to NCH UART channel blocks with ack
// timeout, and hosts a local interrupt pending/mask/status block at select 7.
module uart_reg_fabric #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned SEL_LSB = 6,
  parameter int unsigned TMO     = 255
) (
  input  logic             app_clk,
  input  logic             reset,
  uart_reg_fabric_if.slave host,
  output logic [NCH-1:0]   ch_cs,
  output logic             ch_wr,
  output logic [3:0]       ch_addr,
  output logic [7:0]       ch_wdata,
  output logic             ch_be,
  input  logic [8*NCH-1:0] ch_rdata,
  input  logic [NCH-1:0]   ch_ack,
  input  logic [NCH-1:0]   ch_irq,
  output logic             irq
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, HOLD} state_t;

  localparam logic [2:0]  SEL_LOCAL = 3'd7;
  localparam logic [15:0] TMO_LAST  = 16'(TMO - 1);

  state_t         state;
  logic [2:0]     sel_q;
  logic [15:0]    tmo_cnt;
  logic [31:0]    rdata_q;
  logic           ack_q;
  logic           err_q;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] irq_q;
  logic [NCH-1:0] irq_q2;
  logic [2:0]     to_ch;
  logic           to_flag;

  logic [2:0]     sel_in;
  logic [3:0]     off_in;
  logic           sel_is_ch;
  logic           loc_wr;
  logic [NCH-1:0] cs_dec;
  logic [NCH-1:0] pend_clr;
  logic [NCH-1:0] irq_rise;
  logic           ack_sel;
  logic [7:0]     rdata_sel;
  logic [31:0]    loc_rdata;
  logic           unused_bits;

  assign sel_in      = host.reg_addr[SEL_LSB+2:SEL_LSB];
  assign off_in      = host.reg_addr[5:2];
  assign sel_is_ch   = 32'(sel_in) < NCH;
  assign loc_wr      = (state == IDLE) && host.reg_cs && host.reg_wr && (sel_in == SEL_LOCAL);
  assign irq_rise    = irq_q & ~irq_q2;
  assign pend_clr    = (loc_wr && off_in == 4'h0 && host.reg_be[0]) ? host.reg_wdata[NCH-1:0] : '0;
  assign unused_bits = ^{host.reg_addr, host.reg_wdata, host.reg_be};

  assign host.reg_rdata = rdata_q;
  assign host.reg_ack   = ack_q;
  assign host.reg_err   = err_q;

  always_comb begin
    cs_dec    = '0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cs_dec[i] = (sel_in == 3'(i));
      if (sel_q == 3'(i)) begin
        ack_sel   = ch_ack[i];
        rdata_sel = ch_rdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    loc_rdata = '0;
    case (off_in)
      4'h0:    loc_rdata[NCH-1:0] = pend;
      4'h1:    loc_rdata[NCH-1:0] = mask;
      4'h2:    loc_rdata = {21'b0, to_ch, 7'b0, to_flag};
      default: loc_rdata = '0;
    endcase
  end

  always_ff @(posedge app_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel_q    <= '0;
      tmo_cnt  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      ch_cs    <= '0;
      ch_wr    <= 1'b0;
      ch_addr  <= '0;
      ch_wdata <= '0;
      ch_be    <= 1'b0;
      pend     <= '0;
      mask     <= '0;
      irq_q    <= '0;
      irq_q2   <= '0;
      to_ch    <= '0;
      to_flag  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_q  <= ch_irq;
      irq_q2 <= irq_q;
      // A new edge overrides a simultaneous write-1-to-clear
      pend   <= (pend & ~pend_clr) | irq_rise;
      irq    <= |(pend & mask);

      if (loc_wr && off_in == 4'h1 && host.reg_be[0])
        mask <= host.reg_wdata[NCH-1:0];
      if (loc_wr && off_in == 4'h2) begin
        if (host.reg_be[0]) to_flag <= 1'b0;
        if (host.reg_be[1]) to_ch   <= '0;
      end

      case (state)
        IDLE: begin
          if (host.reg_cs) begin
            sel_q    <= sel_in;
            ch_wr    <= host.reg_wr;
            ch_addr  <= off_in;
            ch_wdata <= host.reg_wdata[7:0];
            ch_be    <= host.reg_be[0];
            if (sel_is_ch) begin
              state   <= ACCESS;
              ch_cs   <= cs_dec;
              tmo_cnt <= '0;
            end else begin
              // Local and unmapped blocks answer straight from the capture edge
              state   <= RESP;
              ack_q   <= 1'b1;
              err_q   <= (sel_in != SEL_LOCAL);
              rdata_q <= (sel_in == SEL_LOCAL && !host.reg_wr) ? loc_rdata : '0;
            end
          end
        end
        ACCESS: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (ack_sel) begin
            state   <= RESP;
            ch_cs   <= '0;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= {24'b0, rdata_sel};
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= RESP;
            ch_cs   <= '0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
            to_ch   <= sel_q;
            to_flag <= 1'b1;
          end
        end
        RESP: begin
          state   <= HOLD;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        HOLD: begin
          if (!host.reg_cs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_reg_fabric.sv
// Randomized bench for uart_reg_fabric checked against a register-level model.
module tb_uart_reg_fabric;
  localparam int NCH = 3;
  localparam int TMO = 4;

  logic             app_clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   ch_cs;
  logic             ch_wr;
  logic [3:0]       ch_addr;
  logic [7:0]       ch_wdata;
  logic             ch_be;
  logic [8*NCH-1:0] ch_rdata;
  logic [NCH-1:0]   ch_ack;
  logic [NCH-1:0]   ch_irq;
  logic             irq;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent host access
  logic        o_got, o_err, o_cs_bad, o_resp_bad, o_wr, o_be;
  logic [31:0] o_rd;
  logic [3:0]  o_addr;
  logic [7:0]  o_wd;
  int          o_cs_cnt, o_lat, o_extra;

  // Reference register state
  logic [NCH-1:0] m_pend, m_mask;
  logic [2:0]     m_to_ch;
  logic           m_to;

  uart_reg_fabric_if host();

  uart_reg_fabric #(.NCH(NCH), .SEL_LSB(6), .TMO(TMO)) dut (
    .app_clk (app_clk),
    .reset   (reset),
    .host    (host),
    .ch_cs   (ch_cs),
    .ch_wr   (ch_wr),
    .ch_addr (ch_addr),
    .ch_wdata(ch_wdata),
    .ch_be   (ch_be),
    .ch_rdata(ch_rdata),
    .ch_ack  (ch_ack),
    .ch_irq  (ch_irq),
    .irq     (irq)
  );

  always #5 app_clk = ~app_clk;

  function automatic logic [31:0] model_read(input logic [3:0] off);
    case (off)
      4'h0:    return 32'(m_pend);
      4'h1:    return 32'(m_mask);
      4'h2:    return {21'b0, m_to_ch, 7'b0, m_to};
      default: return '0;
    endcase
  endfunction

  function automatic void model_write(input logic [3:0] off, input logic [31:0] wd, input logic [3:0] be);
    if (off == 4'h0 && be[0]) m_pend = m_pend & ~wd[NCH-1:0];
    if (off == 4'h1 && be[0]) m_mask = wd[NCH-1:0];
    if (off == 4'h2) begin
      if (be[0]) m_to    = 1'b0;
      if (be[1]) m_to_ch = '0;
    end
  endfunction

  function automatic logic [59:0] resp_vec();
    return {o_got, o_err, o_rd, 8'(o_cs_cnt), 8'(o_lat), 8'(o_extra), o_cs_bad, o_resp_bad};
  endfunction

  // Expected: acked once, given err/rdata, cs_cnt cycles of ch_cs, lat edges to ack, nothing afterwards
  function automatic logic [59:0] exp_vec(input logic err, input logic [31:0] rd, input int cs, input int lat);
    return {1'b1, err, rd, 8'(cs), 8'(lat), 8'd0, 2'b00};
  endfunction

  // Runs one host access from posedge+1; acks the selected channel in its ack_at-th ch_cs cycle.
  task automatic access(input logic [10:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] be, input int ack_at, input logic [7:0] data, input int hold);
    logic [2:0]     s;
    logic [NCH-1:0] sel_cs;
    s        = addr[8:6];
    sel_cs   = '0;
    ch_rdata = 24'($urandom);
    if (int'(s) < NCH) begin
      sel_cs[s] = 1'b1;
      ch_rdata[8*int'(s) +: 8] = data;
    end
    o_got = 0; o_err = 0; o_rd = '0; o_cs_cnt = 0; o_lat = 0; o_extra = 0;
    o_cs_bad = 0; o_resp_bad = 0; o_addr = '0; o_wr = 0; o_wd = '0; o_be = 0;
    host.reg_addr = addr; host.reg_wr = wr; host.reg_wdata = wd; host.reg_be = be;
    host.reg_cs = 1'b1;
    for (int c = 0; c < 40 && !o_got; c++) begin
      @(posedge app_clk); #1;
      o_lat++;
      ch_ack = NCH'($urandom) & ~sel_cs;
      if (host.reg_ack) begin
        o_got = 1; o_rd = host.reg_rdata; o_err = host.reg_err;
      end else begin
        if (host.reg_err || host.reg_rdata != 0) o_resp_bad = 1;
        if (ch_cs != 0) begin
          o_cs_cnt++;
          if (ch_cs !== sel_cs) o_cs_bad = 1;
          o_addr = ch_addr; o_wr = ch_wr; o_wd = ch_wdata; o_be = ch_be;
          if (o_cs_cnt == ack_at) ch_ack = ch_ack | sel_cs;
        end
      end
    end
    for (int h = 0; h < hold + 2; h++) begin
      if (h == hold) host.reg_cs = 1'b0;
      @(posedge app_clk); #1;
      ch_ack = NCH'($urandom);
      if (host.reg_ack || ch_cs != 0 || host.reg_err || host.reg_rdata != 0) o_extra++;
    end
    ch_ack = '0;
  endtask

  task automatic test_reset();
    logic [59:0] e;
    reset = 1'b1;
    host.reg_cs = 0; host.reg_wr = 0; host.reg_addr = '0; host.reg_wdata = '0; host.reg_be = '0;
    ch_rdata = '0; ch_ack = '0; ch_irq = '0;
    repeat (3) @(posedge app_clk);
    #1;
    checks++;
    if ({ch_cs, ch_wr, ch_addr, ch_wdata, ch_be, irq, host.reg_ack, host.reg_err, host.reg_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cs=%b wr=%b addr=%h wd=%h be=%b irq=%b ack=%b err=%b rd=%h, exp all 0",
               ch_cs, ch_wr, ch_addr, ch_wdata, ch_be, irq, host.reg_ack, host.reg_err, host.reg_rdata);
    end
    @(posedge app_clk); #1;
    reset = 1'b0;
    m_pend = '0; m_mask = '0; m_to_ch = '0; m_to = 1'b0;
    for (int off = 0; off < 3; off++) begin
      access(11'h1C0 | 11'(off << 2), 1'b0, $urandom, 4'hF, 0, 8'h00, 0);
      e = exp_vec(1'b0, 32'h0, 0, 1);
      checks++;
      if (resp_vec() !== e) begin
        errors++;
        $display("FAIL reset_local_read_%0d: got %h exp %h", off, resp_vec(), e);
      end
    end
  endtask

  task automatic test_chan_read();
    logic [59:0] e;
    access(11'h044, 1'b0, 32'h0, 4'hF, 3, 8'h5A, 0);
    e = exp_vec(1'b0, 32'h0000005A, 3, 4);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL chan_read_ch1: got %h exp %h", resp_vec(), e);
    end
    checks++;
    if ({o_addr, o_wr} !== {4'h1, 1'b0}) begin
      errors++;
      $display("FAIL chan_read_fields: got addr=%h wr=%b exp addr=1 wr=0", o_addr, o_wr);
    end
  endtask

  task automatic test_timeout();
    logic [59:0] e;
    logic [31:0] wd;
    wd = $urandom;
    access(11'h000, 1'b1, wd, 4'hF, 99, 8'h00, 0);
    e = exp_vec(1'b1, 32'h0, TMO, TMO + 1);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL timeout_ch0: got %h exp %h", resp_vec(), e);
    end
    checks++;
    if ({o_addr, o_wr, o_wd, o_be} !== {4'h0, 1'b1, wd[7:0], 1'b1}) begin
      errors++;
      $display("FAIL timeout_fields: got %h exp %h", {o_addr, o_wr, o_wd, o_be}, {4'h0, 1'b1, wd[7:0], 1'b1});
    end
    m_to = 1'b1; m_to_ch = 3'd0;
    access(11'h1C8, 1'b0, 32'h0, 4'hF, 0, 8'h00, 0);
    e = exp_vec(1'b0, 32'h00000001, 0, 1);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL status_after_to_ch0: got %h exp %h", resp_vec(), e);
    end
    access(11'h098, 1'b0, 32'h0, 4'hF, 99, 8'h00, 0);
    m_to = 1'b1; m_to_ch = 3'd2;
    access(11'h1C8, 1'b1, $urandom, 4'h1, 0, 8'h00, 0);
    model_write(4'h2, 32'h0, 4'h1);
    access(11'h1C8, 1'b0, 32'h0, 4'hF, 0, 8'h00, 0);
    e = exp_vec(1'b0, 32'h00000200, 0, 1);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL status_lane0_clear: got %h exp %h", resp_vec(), e);
    end
    access(11'h1C8, 1'b1, $urandom, 4'h2, 0, 8'h00, 0);
    model_write(4'h2, 32'h0, 4'h2);
    access(11'h1C8, 1'b0, 32'h0, 4'hF, 0, 8'h00, 0);
    e = exp_vec(1'b0, 32'h0, 0, 1);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL status_lane1_clear: got %h exp %h", resp_vec(), e);
    end
  endtask

  task automatic test_unmapped();
    logic [59:0] e;
    logic [10:0] a;
    for (int s = 3; s < 7; s++) begin
      a = (s == 5) ? 11'h140 : {2'b00, 3'(s), 4'($urandom), 2'b00};
      access(a, 1'($urandom), $urandom, 4'hF, 1, 8'($urandom), 0);
      e = exp_vec(1'b1, 32'h0, 0, 1);
      checks++;
      if (resp_vec() !== e) begin
        errors++;
        $display("FAIL unmapped_sel%0d: got %h exp %h", s, resp_vec(), e);
      end
    end
  endtask

  task automatic test_irq();
    logic [59:0] e;
    logic [NCH-1:0] bits, mk;
    access(11'h1C4, 1'b1, 32'h2, 4'h1, 0, 8'h00, 0);
    model_write(4'h1, 32'h2, 4'h1);
    ch_irq = 3'b010;
    @(posedge app_clk); #1;
    ch_irq = '0;
    repeat (3) @(posedge app_clk);
    #1;
    m_pend = m_pend | 3'b010;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_after_pulse: got %b exp 1", irq);
    end
    access(11'h1C0, 1'b0, 32'h0, 4'hF, 0, 8'h00, 0);
    e = exp_vec(1'b0, 32'h2, 0, 1);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL pend_after_pulse: got %h exp %h", resp_vec(), e);
    end
    // New edge lands on the same clock as the W1C capture
    ch_irq = 3'b010;
    @(posedge app_clk); #1;
    access(11'h1C0, 1'b1, 32'h2, 4'hF, 0, 8'h00, 0);
    ch_irq = '0;
    access(11'h1C0, 1'b0, 32'h0, 4'hF, 0, 8'h00, 0);
    e = exp_vec(1'b0, 32'h2, 0, 1);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL pend_set_beats_clear: got %h exp %h", resp_vec(), e);
    end
    for (int k = 0; k < 6; k++) begin
      bits = NCH'($urandom);
      mk   = NCH'($urandom);
      ch_irq = bits;
      @(posedge app_clk); #1;
      ch_irq = '0;
      repeat (3) @(posedge app_clk);
      #1;
      m_pend = m_pend | bits;
      access(11'h1C4, 1'b1, 32'(mk), 4'h1, 0, 8'h00, 0);
      model_write(4'h1, 32'(mk), 4'h1);
      access(11'h1C0, 1'b0, 32'h0, 4'hF, 0, 8'h00, 0);
      e = exp_vec(1'b0, 32'(m_pend), 0, 1);
      checks++;
      if (resp_vec() !== e) begin
        errors++;
        $display("FAIL pend_random_%0d: got %h exp %h", k, resp_vec(), e);
      end
      checks++;
      if (irq !== |(m_pend & m_mask)) begin
        errors++;
        $display("FAIL irq_random_%0d: got %b exp %b", k, irq, |(m_pend & m_mask));
      end
      bits = NCH'($urandom);
      access(11'h1C0, 1'b1, 32'(bits), 4'h1, 0, 8'h00, 0);
      model_write(4'h0, 32'(bits), 4'h1);
    end
  endtask

  task automatic test_back_to_back();
    logic [59:0] e;
    logic [7:0]  d;
    d = 8'($urandom);
    access(11'h084, 1'b0, 32'h0, 4'hF, 2, d, 5);
    e = exp_vec(1'b0, {24'h0, d}, 2, 3);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL hold_cs_single_burst: got %h exp %h", resp_vec(), e);
    end
    access(11'h004, 1'b0, 32'h0, 4'hF, 1, d ^ 8'hFF, 0);
    e = exp_vec(1'b0, {24'h0, d ^ 8'hFF}, 1, 2);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL back_to_back_ch0: got %h exp %h", resp_vec(), e);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [59:0] e;
    logic        ack_seen;
    access(11'h1C4, 1'b1, 32'h5, 4'h1, 0, 8'h00, 0);
    host.reg_addr = 11'h000; host.reg_wr = 1'b0; host.reg_be = 4'hF; host.reg_cs = 1'b1;
    @(posedge app_clk); #1;
    @(posedge app_clk); #1;
    checks++;
    if (ch_cs !== 3'b001) begin
      errors++;
      $display("FAIL pre_reset_cs: got %b exp 001", ch_cs);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ch_cs !== 3'b000) begin
      errors++;
      $display("FAIL async_cs_drop: got %b exp 000", ch_cs);
    end
    host.reg_cs = 1'b0;
    ack_seen = 1'b0;
    repeat (2) begin
      @(posedge app_clk); #1;
      if (host.reg_ack) ack_seen = 1'b1;
    end
    reset = 1'b0;
    m_pend = '0; m_mask = '0; m_to_ch = '0; m_to = 1'b0;
    repeat (3) begin
      @(posedge app_clk); #1;
      if (host.reg_ack || ch_cs != 0) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen !== 1'b0) begin
      errors++;
      $display("FAIL aborted_access_ack: got %b exp 0", ack_seen);
    end
    access(11'h1C4, 1'b0, 32'h0, 4'hF, 0, 8'h00, 0);
    e = exp_vec(1'b0, 32'h0, 0, 1);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL mask_after_reset: got %h exp %h", resp_vec(), e);
    end
    access(11'h088, 1'b0, 32'h0, 4'hF, 1, 8'hC3, 0);
    e = exp_vec(1'b0, 32'h000000C3, 1, 2);
    checks++;
    if (resp_vec() !== e) begin
      errors++;
      $display("FAIL access_after_reset: got %h exp %h", resp_vec(), e);
    end
  endtask

  task automatic test_random();
    logic [59:0] e;
    logic [2:0]  s;
    logic [3:0]  off, be;
    logic        wr;
    logic [31:0] wd;
    logic [7:0]  d8;
    int          d;
    for (int k = 0; k < 60; k++) begin
      s = 3'($urandom); off = 4'($urandom); wr = 1'($urandom); wd = $urandom;
      be = 4'($urandom); d = $urandom_range(1, TMO + 1); d8 = 8'($urandom);
      access({2'($urandom), s, off, 2'($urandom)}, wr, wd, be, d, d8, $urandom_range(0, 2));
      if (int'(s) < NCH) begin
        if (d <= TMO) e = exp_vec(1'b0, {24'h0, d8}, d, d + 1);
        else begin
          e = exp_vec(1'b1, 32'h0, TMO, TMO + 1);
          m_to = 1'b1; m_to_ch = s;
        end
        checks++;
        if ({o_addr, o_wr, o_wd, o_be} !== {off, wr, wd[7:0], be[0]}) begin
          errors++;
          $display("FAIL rand_fields_%0d: got %h exp %h", k, {o_addr, o_wr, o_wd, o_be}, {off, wr, wd[7:0], be[0]});
        end
      end else if (s == 3'd7) begin
        e = exp_vec(1'b0, wr ? 32'h0 : model_read(off), 0, 1);
        if (wr) model_write(off, wd, be);
      end else begin
        e = exp_vec(1'b1, 32'h0, 0, 1);
      end
      checks++;
      if (resp_vec() !== e) begin
        errors++;
        $display("FAIL rand_resp_%0d sel=%0d: got %h exp %h", k, s, resp_vec(), e);
      end
      checks++;
      if (irq !== |(m_pend & m_mask)) begin
        errors++;
        $display("FAIL rand_irq_%0d: got %b exp %b", k, irq, |(m_pend & m_mask));
      end
    end
  endtask

  initial begin
    test_reset();
    test_chan_read();
    test_timeout();
    test_unmapped();
    test_irq();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, exp completion");
    $fatal(1);
  end
endmodule

// File: doc/uart_reg_fabric.md
UART_REG_FABRIC -- requirements
Module: uart_reg_fabric

Interface
REQ-001 SHALL have parameter NCH, default 3, giving the number of UART channels (legal 1..7).
REQ-002 SHALL have parameter SEL_LSB, default 6, giving the low bit of the block-select field in reg_addr.
REQ-003 SHALL have parameter TMO, default 255, giving the channel ack timeout in app_clk cycles (legal 2..65535).
REQ-004 SHALL have port app_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports reg_cs/reg_wr, input, 1 each: host access request and write qualifier.
REQ-007 SHALL have port reg_addr, input, 11: host byte address; bits [SEL_LSB+2:SEL_LSB] form block select sel.
REQ-008 SHALL have ports reg_wdata, input, 32 and reg_be, input, 4: host write data and byte enables.
REQ-009 SHALL have ports reg_rdata, output, 32; reg_ack, output, 1; reg_err, output, 1: host response.
REQ-010 SHALL have ports ch_cs, output, NCH and ch_wr, output, 1: per-channel select and shared write qualifier.
REQ-011 SHALL have ports ch_addr, output, 4 (captured reg_addr[5:2]); ch_wdata, output, 8; ch_be, output, 1 (captured reg_be[0]).
REQ-012 SHALL have ports ch_rdata, input, 8*NCH; ch_ack, input, NCH; ch_irq, input, NCH: per-channel response and interrupt.
REQ-013 SHALL have port irq, output, 1: aggregated masked interrupt.

Function
REQ-014 SHALL implement FSM IDLE, ACCESS, RESP, HOLD.
REQ-015 In IDLE with reg_cs=1, SHALL capture sel, reg_addr[5:2], reg_wr, reg_wdata, and reg_be.
REQ-016 On capture with sel<NCH, SHALL go to ACCESS; with sel=7 (local block) or NCH<=sel<7 (unmapped), SHALL go to RESP directly.
REQ-017 In ACCESS, SHALL hold ch_cs[sel]=1 and all other ch_cs bits 0, with ch_wr/ch_addr/ch_wdata/ch_be driven from captured values.
REQ-018 In ACCESS, when ch_ack[sel]=1, SHALL register ch_rdata[sel] zero-extended to 32 bits and go to RESP; ch_cs SHALL drop the following cycle.
REQ-019 Ack on a non-selected channel SHALL be ignored.
REQ-020 SHALL run a 16-bit timeout counter, cleared on ACCESS entry and incremented each ACCESS cycle.
REQ-021 When the timeout count reaches TMO-1 with no ack, SHALL go to RESP with err=1, rdata=0, and STATUS.TO_CH=sel, STATUS.TO=1.
REQ-022 In RESP, SHALL assert reg_ack=1 for exactly one cycle with reg_rdata/reg_err valid, then go to HOLD.
REQ-023 HOLD SHALL wait until reg_cs=0, then go to IDLE, so no access restarts from a stale reg_cs.
REQ-024 Outside RESP, reg_ack=0, reg_err=0, and reg_rdata=0.
REQ-025 Latency: a reg_cs sampled in cycle n with a same-cycle channel ack SHALL give reg_ack in cycle n+2; local or unmapped access SHALL give reg_ack in n+1.
REQ-026 An unmapped access SHALL ack with err=1 and rdata=0; writes to it SHALL be discarded.
REQ-027 Local block offset 0x0 SHALL be IRQ_PEND[NCH-1:0] (write-1-to-clear); 0x4 IRQ_MASK (RW, reset 0); 0x8 STATUS {TO_CH[10:8], TO[0]} (write any value to clear). Other local offsets SHALL read 0 with no error.
REQ-028 Local writes SHALL honour reg_be per byte lane.
REQ-029 SHALL register ch_irq each cycle; IRQ_PEND[i] SHALL set on a 0->1 edge of the registered ch_irq[i].
REQ-030 When an IRQ_PEND set and a W1C clear occur in the same cycle, set SHALL win.
REQ-031 irq SHALL be a register equal to |(IRQ_PEND & IRQ_MASK), lagging pend/mask by one cycle.

Reset
REQ-032 While reset=1, SHALL force FSM=IDLE, all outputs 0, IRQ_PEND/IRQ_MASK/STATUS/counter/captured fields 0, and the registered ch_irq to 0.
REQ-033 Reset asserted mid-ACCESS SHALL drop ch_cs asynchronously, with no reg_ack ever issued for the aborted access.
REQ-034 After reset release, SHALL accept a new access only on a fresh reg_cs sampled in IDLE.

Verification
REQ-035 Read ch1 (addr 0x044), ch_ack[1] in the 3rd ACCESS cycle with ch_rdata[15:8]=0x5A -> ch_cs=3'b010 for 3 cycles; reg_ack 1 cycle with rdata=0x0000005A, err=0.
REQ-036 Write ch0 with TMO=4 and no ack -> ch_cs[0] high for 4 cycles; reg_ack with err=1, rdata=0; STATUS reads 0x00000001.
REQ-037 Access sel=5 with NCH=3 (addr 0x140) -> reg_ack next cycle with err=1; no ch_cs asserted.
REQ-038 Write MASK=0x2 (0x1C4), pulse ch_irq[1] -> PEND=0x2 and irq=1; W1C 0x2 in the same cycle as a new ch_irq[1] edge -> PEND stays 0x2.
REQ-039 Hold reg_cs high 5 cycles after reg_ack -> exactly one ch_cs burst and one reg_ack.
REQ-040 Assert reset during ACCESS -> ch_cs=0 immediately; no reg_ack; next access completes normally.
